// File: rtl/bnn_asm_array.sv
// Binary accumulate-and-threshold array for one BNN conv layer: registered input stage,
// per-channel signed accumulators, per-group batch-norm threshold. Optional macro: BNN_ASM_SAT_EN.
module bnn_asm_array #(
  parameter int NUM_GROUPS   = 4,
  parameter int CH_PER_GROUP = 8,
  parameter int PIX_W        = 2,
  parameter int ACC_W        = 16,
  parameter int BN_W         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [NUM_GROUPS-1:0]         grp_en,
  input  logic [NUM_GROUPS*PIX_W-1:0]   pix_in,
  input  logic [NUM_GROUPS*CH_PER_GROUP-1:0] weight_in,
  input  logic [NUM_GROUPS*BN_W-1:0]    thr_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_GROUPS*CH_PER_GROUP-1:0] data_out,
  output logic [15:0]                   frame_cnt
);

  localparam int NUM_CH = NUM_GROUPS * CH_PER_GROUP;
  localparam int CMP_W  = (ACC_W > BN_W) ? ACC_W : BN_W;

  logic                        s1_valid;
  logic                        s1_last;
  logic [NUM_GROUPS*PIX_W-1:0] s1_pix;
  logic [NUM_CH-1:0]           s1_w;
  logic [NUM_GROUPS-1:0]       s1_en;
  logic [NUM_GROUPS*BN_W-1:0]  s1_thr;
  logic                        s1_adv;
  logic                        accept;

  logic [NUM_CH-1:0][ACC_W-1:0] acc;
  logic [NUM_CH-1:0][ACC_W-1:0] sum_all;
  logic [NUM_CH-1:0]            ge;

  // A last beat may only leave stage 1 if the output register is free or being drained.
  assign s1_adv   = s1_valid & ~(s1_last & out_valid & ~out_ready);
  assign in_ready = ~s1_valid | s1_adv;
  assign accept   = in_valid & in_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int G = c / CH_PER_GROUP;

    logic signed [ACC_W:0]   pix_ext;
    logic signed [ACC_W:0]   term;
    logic signed [ACC_W:0]   wide;
    logic signed [ACC_W-1:0] sum;
    logic signed [BN_W-1:0]  thr_g;
    logic signed [CMP_W-1:0] sum_cmp;
    logic signed [CMP_W-1:0] thr_cmp;

    // One guard bit above ACC_W makes overflow visible before wrap/saturate.
    always_comb begin
      pix_ext = '0;
      pix_ext[PIX_W-1:0] = s1_pix[G*PIX_W +: PIX_W];
      term = s1_w[c] ? pix_ext : -pix_ext;
      wide = {acc[c][ACC_W-1], acc[c]};
      if (s1_en[G]) begin
        wide = wide + term;
      end
`ifdef BNN_ASM_SAT_EN
      if (wide[ACC_W] != wide[ACC_W-1]) begin
        sum = '0;
        sum[ACC_W-1] = wide[ACC_W];
        for (int unsigned i = 0; i < ACC_W - 1; i++) begin
          sum[i] = ~wide[ACC_W];
        end
      end else begin
        sum = wide[ACC_W-1:0];
      end
`else
      sum = wide[ACC_W-1:0];
`endif
    end

    assign thr_g      = s1_thr[G*BN_W +: BN_W];
    assign sum_cmp    = CMP_W'(sum);
    assign thr_cmp    = CMP_W'(thr_g);
    assign ge[c]      = (sum_cmp >= thr_cmp);
    assign sum_all[c] = sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_pix    <= '0;
      s1_w      <= '0;
      s1_en     <= '0;
      s1_thr    <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      frame_cnt <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_last  <= in_last;
        s1_pix   <= pix_in;
        s1_w     <= weight_in;
        s1_en    <= grp_en;
        s1_thr   <= thr_in;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv && !s1_last) begin
        acc <= sum_all;
      end

      // s1_adv with a last beat implies the output register is empty or draining this cycle.
      if (s1_adv && s1_last) begin
        acc       <= '0;
        data_out  <= ge;
        out_valid <= 1'b1;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
